// File: rtl/uart_cmd_rx_if.sv
// Byte-level output bundle of the command UART receiver.
// The master is the receiver; the slave is the downstream command decoder.
interface uart_cmd_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_data, output rx_valid, output frame_err, output busy);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_cmd_rx.sv
// 8N1 UART receiver: start-glitch rejection, mid-bit sampling, stop-bit check.
// rx_valid arrives 9.5 bit periods + 3 clk after the raw start edge; there is no backpressure.
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx,
  uart_cmd_rx_if.master cmd
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       sh, sh_n;
  logic             rx_meta, rxs;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, frame_err_q;
  logic             valid_set, err_set;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    sh_n      = sh;
    valid_set = 1'b0;
    err_set   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        // A start bit still low at half period is real; otherwise it was noise.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = 3'd0;
          state_n   = rxs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n         = '0;
          sh_n[bit_idx] = rxs;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rxs) begin
            valid_set = 1'b1;
            state_n   = IDLE;
          end else begin
            err_set = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BRK: begin
        // Held-low line: stay here so a break yields a single frame_err.
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      sh          <= 8'h00;
      rx_meta     <= 1'b1;
      rxs         <= 1'b1;
      rx_data_q   <= 8'hFE;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_meta     <= rx;
      rxs         <= rx_meta;
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_idx_n;
      sh          <= sh_n;
      rx_valid_q  <= valid_set;
      frame_err_q <= err_set;
      if (valid_set) rx_data_q <= sh;
    end
  end

  assign cmd.rx_data   = rx_data_q;
  assign cmd.rx_valid  = rx_valid_q;
  assign cmd.frame_err = frame_err_q;
  assign cmd.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx: frame-level model (expected byte queue, pending errors) checked every cycle.
module tb_uart_cmd_rx;
  localparam int CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_cmd_rx_if cmd ();

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .cmd (cmd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Model: bytes the line carried with a good stop bit, in order, and count of bad-stop frames.
  logic [7:0] exp_q[$];
  int         err_pend = 0;
  logic [7:0] model_data = 8'hFE;
  int         n_valid = 0;
  int         n_err = 0;
  int         last_valid_cyc = 0;
  int         last_start_cyc = 0;
  bit         busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Per-cycle compare, sampled 1 time unit after the active edge.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      exp_q.delete();
      err_pend   = 0;
      model_data = 8'hFE;
      chk("reset_valid", 32'(cmd.rx_valid), 32'h0);
      chk("reset_ferr", 32'(cmd.frame_err), 32'h0);
      chk("reset_busy", 32'(cmd.busy), 32'h0);
      chk("reset_data", 32'(cmd.rx_data), 32'hFE);
    end else begin
      chk("valid_ferr_exclusive", 32'(cmd.rx_valid & cmd.frame_err), 32'h0);
      if (cmd.busy) busy_seen = 1'b1;
      if (cmd.rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
        chk("busy_low_at_valid", 32'(cmd.busy), 32'h0);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL spurious_valid: got pulse with data %0h, expected none", cmd.rx_data);
        end else begin
          model_data = exp_q.pop_front();
        end
      end
      if (cmd.frame_err) begin
        n_err++;
        checks++;
        if (err_pend == 0) begin
          failures++;
          $display("FAIL spurious_frame_err: got pulse, expected none");
        end else begin
          err_pend--;
        end
      end
      chk("rx_data_vs_model", 32'(cmd.rx_data), 32'(model_data));
    end
  end

  // All stimulus tasks start and end on a negedge.
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit stop_ok, input int p100, input int stop_hold);
    logic [9:0] bits;
    int len;
    bits = {stop_ok, b, 1'b0};
    if (stop_ok) exp_q.push_back(b);
    else         err_pend++;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      if (k == 0) last_start_cyc = cyc;
      len = ((k + 1) * p100) / 100 - (k * p100) / 100;
      if (k == 9 && !stop_ok) len = stop_hold;
      repeat (len) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int e0;
    int periods[2];
    periods[0] = 1648;
    periods[1] = 1552;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: idle line
    idle(100);
    chk("t1_data", 32'(cmd.rx_data), 32'hFE);
    chk("t1_no_valid", 32'(n_valid), 32'h0);
    chk("t1_no_ferr", 32'(n_err), 32'h0);
    chk("t1_busy", 32'(cmd.busy), 32'h0);

    // 2: single byte; pulse 2 sync + 1 detect + 8 + 9*16 = 155 clk after the start edge
    v0 = n_valid;
    send(8'h02, 1'b1, CPB * 100, 0);
    idle(40);
    chk("t2_one_valid", 32'(n_valid - v0), 32'h1);
    chk("t2_data", 32'(cmd.rx_data), 32'h02);
    chk("t2_latency", 32'(last_valid_cyc - last_start_cyc), 32'd155);

    // 3: 6-clk low glitch
    v0 = n_valid;
    e0 = n_err;
    busy_seen = 1'b0;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    idle(40);
    chk("t3_busy_pulsed", 32'(busy_seen), 32'h1);
    chk("t3_no_valid", 32'(n_valid - v0), 32'h0);
    chk("t3_no_ferr", 32'(n_err - e0), 32'h0);
    chk("t3_busy_back_low", 32'(cmd.busy), 32'h0);

    // 4: good frame, then bad-stop frame with the line held low
    v0 = n_valid;
    e0 = n_err;
    send(8'h05, 1'b1, CPB * 100, 0);
    idle(20);
    send(8'h03, 1'b0, CPB * 100, 40);
    idle(40);
    chk("t4_one_valid", 32'(n_valid - v0), 32'h1);
    chk("t4_one_ferr", 32'(n_err - e0), 32'h1);
    chk("t4_data_kept", 32'(cmd.rx_data), 32'h05);

    // 5: back-to-back frames at +3% and -3% bit period
    foreach (periods[i]) begin
      v0 = n_valid;
      send(8'h00, 1'b1, periods[i], 0);
      send(8'h01, 1'b1, periods[i], 0);
      send(8'h04, 1'b1, periods[i], 0);
      idle(40);
      chk("t5_three_valid", 32'(n_valid - v0), 32'h3);
      chk("t5_last_data", 32'(cmd.rx_data), 32'h04);
    end

    // 6: reset in the middle of bit 4, then a clean frame
    v0 = n_valid;
    rx = 1'b0;
    repeat (CPB * 5 + 8) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b0;
    idle(40);
    chk("t6_no_valid_abort", 32'(n_valid - v0), 32'h0);
    chk("t6_data_after_rst", 32'(cmd.rx_data), 32'hFE);
    send(8'h06, 1'b1, CPB * 100, 0);
    idle(40);
    chk("t6_one_valid", 32'(n_valid - v0), 32'h1);
    chk("t6_data", 32'(cmd.rx_data), 32'h06);

    chk("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    chk("ferr_all_seen", 32'(err_pend), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
